// File: rtl/robertson_ctrl_if.sv
// Handshake and datapath-control bundle between the Robertson controller and its host/datapath.
// The host/datapath side uses master; the controller uses slave.
interface robertson_ctrl_if #(
  parameter int unsigned N = 8
);
  localparam int unsigned CW = $clog2(N);

  logic          start;
  logic          q0;
  logic          m_sign;
  logic          ld_regs;
  logic          add_en;
  logic          sub_en;
  logic          shift_en;
  logic [2:0]    shin_sel;
  logic          f;
  logic [CW-1:0] cnt;
  logic          busy;
  logic          done;

  modport master (
    output start, q0, m_sign,
    input  ld_regs, add_en, sub_en, shift_en, shin_sel, f, cnt, busy, done
  );

  modport slave (
    input  start, q0, m_sign,
    output ld_regs, add_en, sub_en, shift_en, shin_sel, f, cnt, busy, done
  );
endinterface

// File: rtl/robertson_ctrl.sv
// Control FSM for an N-bit signed Robertson shift-add multiplier; owns F and the iteration counter.
// Optional abort input enabled by defining ROBERTSON_CTRL_ABORT_EN.
module robertson_ctrl #(
  parameter int unsigned N = 8
) (
  input  logic             clk,
  input  logic             reset,
`ifdef ROBERTSON_CTRL_ABORT_EN
  input  logic             abort,
`endif
  robertson_ctrl_if.slave  bus
);

  localparam int unsigned CW = $clog2(N);

  localparam logic [2:0] SEL_F    = 3'd0;
  localparam logic [2:0] SEL_A    = 3'd1;
  localparam logic [2:0] SEL_ZERO = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TEST,
    S_ADD,
    S_SHIFT,
    S_SUB,
    S_SHIFT_LAST,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic          f_q, f_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          ld_regs_q, ld_regs_d;
  logic          add_en_q, add_en_d;
  logic          sub_en_q, sub_en_d;
  logic          shift_en_q, shift_en_d;
  logic [2:0]    shin_sel_q, shin_sel_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Next-state, F/counter update, and strobes decoded from the next state so they register in step with it
  always_comb begin
    state_d = state_q;
    f_d     = f_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_LOAD;
      end
      S_LOAD: begin
        f_d     = 1'b0;
        cnt_d   = CW'(N - 1);
        state_d = S_TEST;
      end
      S_TEST: begin
        if (cnt_q != '0) state_d = bus.q0 ? S_ADD : S_SHIFT;
        else             state_d = bus.q0 ? S_SUB : S_SHIFT_LAST;
      end
      S_ADD: begin
        f_d     = f_q | bus.m_sign;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        cnt_d   = cnt_q - CW'(1);
        state_d = S_TEST;
      end
      S_SUB:        state_d = S_SHIFT_LAST;
      S_SHIFT_LAST: state_d = S_DONE;
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase

`ifdef ROBERTSON_CTRL_ABORT_EN
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      f_d     = 1'b0;
      cnt_d   = '0;
    end
`endif

    ld_regs_d  = (state_d == S_LOAD);
    add_en_d   = (state_d == S_ADD);
    sub_en_d   = (state_d == S_SUB);
    shift_en_d = (state_d == S_SHIFT) || (state_d == S_SHIFT_LAST);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    if (state_d == S_SHIFT)           shin_sel_d = SEL_F;
    else if (state_d == S_SHIFT_LAST) shin_sel_d = SEL_A;
    else                              shin_sel_d = SEL_ZERO;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      f_q        <= 1'b0;
      cnt_q      <= '0;
      ld_regs_q  <= 1'b0;
      add_en_q   <= 1'b0;
      sub_en_q   <= 1'b0;
      shift_en_q <= 1'b0;
      shin_sel_q <= SEL_ZERO;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      f_q        <= f_d;
      cnt_q      <= cnt_d;
      ld_regs_q  <= ld_regs_d;
      add_en_q   <= add_en_d;
      sub_en_q   <= sub_en_d;
      shift_en_q <= shift_en_d;
      shin_sel_q <= shin_sel_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.ld_regs  = ld_regs_q;
  assign bus.add_en   = add_en_q;
  assign bus.sub_en   = sub_en_q;
  assign bus.shift_en = shift_en_q;
  assign bus.shin_sel = shin_sel_q;
  assign bus.f        = f_q;
  assign bus.cnt      = cnt_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_robertson_ctrl.sv
// Directed bench for robertson_ctrl with a reference shift-add datapath around it.
module tb_robertson_ctrl;

  logic clk = 1'b0;
  logic reset;
`ifdef ROBERTSON_CTRL_ABORT_EN
  logic abort;
`endif

  robertson_ctrl_if #(.N(8)) bus ();

  robertson_ctrl #(.N(8)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef ROBERTSON_CTRL_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // 0: inputs come from the datapath model; 1: q0=0,m_sign=0; 2: q0=1,m_sign=1
  int mode;
  logic [7:0] mc_in, mp_in;
  logic [7:0] am, qm, mm;
  logic       sin;

  assign sin = (bus.shin_sel == 3'd0) ? bus.f :
               (bus.shin_sel == 3'd1) ? am[7] : 1'b0;

  always @(posedge clk) begin
    if (bus.ld_regs) begin
      am <= 8'h00;
      qm <= mp_in;
      mm <= mc_in;
    end else if (bus.add_en) begin
      am <= am + mm;
    end else if (bus.sub_en) begin
      am <= am - mm;
    end else if (bus.shift_en) begin
      {am, qm} <= {sin, am, qm[7:1]};
    end
  end

  assign bus.q0     = (mode == 0) ? qm[0] : (mode == 2);
  assign bus.m_sign = (mode == 0) ? mm[7] : (mode == 2);

  int done_at, sub_at, sl_at, first_add, n_add, n_shift, n_done, n_ld;
  int bad_strobe, bad_sel, f_viol;
  logic f_at_done;
  logic [15:0] prod;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start an op; leaves the sim at cycle t (the LOAD cycle)
  task automatic start_op(input string tag);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk({tag, " ld_regs at t"}, 32'(bus.ld_regs), 32'd1);
  endtask

  // Observe cycles t+1..t+ncyc; inject=1 pulses start while busy and during DONE
  task automatic observe(input int ncyc, input bit inject);
    done_at = -1; sub_at = -1; sl_at = -1; first_add = -1;
    n_add = 0; n_shift = 0; n_done = 0; n_ld = 0;
    bad_strobe = 0; bad_sel = 0; f_viol = 0; f_at_done = 1'bx; prod = 'x;
    for (int c = 1; c <= ncyc; c++) begin
      step();
      if (bus.done) begin
        n_done++;
        if (done_at < 0) begin
          done_at   = c;
          f_at_done = bus.f;
          prod      = {am, qm};
        end
      end
      if (bus.sub_en && sub_at < 0) sub_at = c;
      if (bus.shin_sel == 3'd1 && sl_at < 0) sl_at = c;
      if (bus.add_en) begin
        n_add++;
        if (first_add < 0) first_add = c;
      end
      if (bus.shift_en) n_shift++;
      if (bus.ld_regs) n_ld++;
      if (32'(bus.ld_regs) + 32'(bus.add_en) + 32'(bus.sub_en) + 32'(bus.shift_en) > 1) bad_strobe++;
      if (!(bus.shin_sel inside {3'd0, 3'd1, 3'd5}) ||
          (bus.shift_en && bus.shin_sel == 3'd5) ||
          (!bus.shift_en && bus.shin_sel != 3'd5)) bad_sel++;
      if (first_add > 0 && c > first_add && c <= done_at + 0 + (done_at < 0 ? ncyc : 0) && !bus.f) f_viol++;
      bus.start = inject && (c == 5 || bus.done);
    end
    bus.start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
`ifdef ROBERTSON_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    mode = 1;
    mc_in = 8'h00;
    mp_in = 8'h00;
    step();
    step();
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset strobes", 32'({bus.ld_regs, bus.add_en, bus.sub_en, bus.shift_en}), 32'd0);
    chk("reset shin_sel", 32'(bus.shin_sel), 32'd5);
    chk("reset cnt", 32'(bus.cnt), 32'd0);
    chk("reset f", 32'(bus.f), 32'd0);
    reset = 1'b0;
    step();
    chk("idle busy", 32'(bus.busy), 32'd0);

    // q0 held 0: pure shifting
    mode = 1;
    start_op("q0=0");
    observe(30, 1'b0);
    chk("q0=0 done_at", 32'(done_at), 32'd17);
    chk("q0=0 shin_sel=1 at", 32'(sl_at), 32'd16);
    chk("q0=0 shifts", 32'(n_shift), 32'd8);
    chk("q0=0 adds", 32'(n_add), 32'd0);
    chk("q0=0 sub_at", 32'(sub_at), 32'hFFFF_FFFF);
    chk("q0=0 f", 32'(f_at_done), 32'd0);
    chk("q0=0 one done", 32'(n_done), 32'd1);
    chk("q0=0 strobe onehot", 32'(bad_strobe), 32'd0);
    chk("q0=0 shin_sel decode", 32'(bad_sel), 32'd0);

    // q0 held 1, m_sign=1: add every iteration then final subtract
    mode = 2;
    start_op("q0=1");
    observe(30, 1'b0);
    chk("q0=1 done_at", 32'(done_at), 32'd25);
    chk("q0=1 sub_at", 32'(sub_at), 32'd23);
    chk("q0=1 first add", 32'(first_add), 32'd2);
    chk("q0=1 adds", 32'(n_add), 32'd7);
    chk("q0=1 shifts", 32'(n_shift), 32'd8);
    chk("q0=1 f sticky", 32'(f_viol), 32'd0);
    chk("q0=1 f", 32'(f_at_done), 32'd1);
    chk("q0=1 strobe onehot", 32'(bad_strobe), 32'd0);
    chk("q0=1 shin_sel decode", 32'(bad_sel), 32'd0);

    // -3 * 5 through the datapath model
    mode = 0;
    mc_in = 8'hFD;
    mp_in = 8'h05;
    start_op("-3*5");
    observe(30, 1'b0);
    chk("-3*5 done_at", 32'(done_at), 32'd19);
    chk("-3*5 product", 32'(prod), 32'h0000_FFF1);
    chk("-3*5 one done", 32'(n_done), 32'd1);

    // 7 * -1 with stray start pulses while busy and in DONE
    mc_in = 8'h07;
    mp_in = 8'hFF;
    start_op("7*-1");
    observe(60, 1'b1);
    chk("7*-1 done_at", 32'(done_at), 32'd25);
    chk("7*-1 product", 32'(prod), 32'h0000_FFF9);
    chk("7*-1 one done", 32'(n_done), 32'd1);
    chk("7*-1 no reload", 32'(n_ld), 32'd0);
    chk("7*-1 idle after", 32'(bus.busy), 32'd0);

    // Reset landing in the first ADD state
    mode = 2;
    start_op("rst");
    step();
    step();
    chk("rst add_en at t+2", 32'(bus.add_en), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst shin_sel", 32'(bus.shin_sel), 32'd5);
    chk("rst cnt", 32'(bus.cnt), 32'd0);
    chk("rst f", 32'(bus.f), 32'd0);
    chk("rst strobes", 32'({bus.ld_regs, bus.add_en, bus.sub_en, bus.shift_en}), 32'd0);
    observe(30, 1'b0);
    chk("rst no done", 32'(n_done), 32'd0);
    chk("rst stays idle", 32'(bus.busy), 32'd0);

`ifdef ROBERTSON_CTRL_ABORT_EN
    mode = 1;
    start_op("abort");
    for (int i = 0; i < 5; i++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort done", 32'(bus.done), 32'd0);
    chk("abort cnt", 32'(bus.cnt), 32'd0);
    chk("abort shin_sel", 32'(bus.shin_sel), 32'd5);
    start_op("after abort");
    observe(30, 1'b0);
    chk("after abort done_at", 32'(done_at), 32'd17);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
